// File: rtl/ddr_burst_splitter_pkg.sv
// Shared configuration for the DDR1 front-end: address geometry helpers,
// burst limits and the splitter state encoding.
package ddr_cfg_pkg;

  // Longest burst the controller accepts, in beats.
  localparam int MAX_BURST = 256;

  // Width of the beats-remaining counter (a request holds at most 4096 beats).
  localparam int REM_BITS = 13;

  // Width of the client length field (beats minus one).
  localparam int LEN_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE,
    ST_WDATA,
    ST_WRESP,
    ST_RDATA,
    ST_DONE
  } split_state_t;

  // Byte address width for a given DRAM geometry and data width level.
  function automatic int addr_width(input int ba_bits, input int row_bits,
                                    input int col_bits, input int dq_level);
    return ba_bits + row_bits + col_bits + dq_level - 1;
  endfunction

  // Number of data beats in one DRAM row.
  function automatic int beats_per_row(input int col_bits);
    return 1 << (col_bits - 1);
  endfunction

endpackage

// File: rtl/ddr_burst_splitter_if.sv
// Client and controller signal bundle for the burst splitter. The slave
// modport is the splitter's view, the master modport is the view of the
// surrounding client plus controller.
interface ddr_burst_splitter_if #(
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 11,
  parameter int DQ_LEVEL = 1
);
  import ddr_cfg_pkg::*;

  localparam int A = addr_width(BA_BITS, ROW_BITS, COL_BITS, DQ_LEVEL);
  localparam int D = 8 << DQ_LEVEL;

  // Client command port
  logic                cmd_valid;
  logic                cmd_ready;
  logic                cmd_write;
  logic [A-1:0]        cmd_addr;
  logic [LEN_BITS-1:0] cmd_len;
  logic                cmd_done;

  // Client write data
  logic         s_wvalid;
  logic         s_wready;
  logic [D-1:0] s_wdata;

  // Client read data
  logic         s_rvalid;
  logic         s_rready;
  logic         s_rlast;
  logic [D-1:0] s_rdata;

  // Controller write address / data / response
  logic         awvalid;
  logic         awready;
  logic [A-1:0] awaddr;
  logic [7:0]   awlen;
  logic         wvalid;
  logic         wready;
  logic         wlast;
  logic [D-1:0] wdata;
  logic         bvalid;
  logic         bready;

  // Controller read address / data
  logic         arvalid;
  logic         arready;
  logic [A-1:0] araddr;
  logic [7:0]   arlen;
  logic         rvalid;
  logic         rready;
  logic         rlast;
  logic [D-1:0] rdata;

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready, cmd_done,
    input  s_wvalid, s_wdata,
    output s_wready,
    input  s_rready,
    output s_rvalid, s_rlast, s_rdata,
    output awvalid, awaddr, awlen,
    input  awready,
    output wvalid, wlast, wdata,
    input  wready,
    input  bvalid,
    output bready,
    output arvalid, araddr, arlen,
    input  arready,
    input  rvalid, rlast, rdata,
    output rready
  );

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready, cmd_done,
    output s_wvalid, s_wdata,
    input  s_wready,
    output s_rready,
    input  s_rvalid, s_rlast, s_rdata,
    input  awvalid, awaddr, awlen,
    output awready,
    input  wvalid, wlast, wdata,
    output wready,
    output bvalid,
    input  bready,
    input  arvalid, araddr, arlen,
    output arready,
    output rvalid, rlast, rdata,
    input  rready
  );

endinterface

// File: rtl/ddr_burst_splitter_calc.sv
// Sub-burst length calculator: the next burst is the smallest of the beats
// still owed, the controller's burst limit and the beats left in the row.
module ddr_split_calc
  import ddr_cfg_pkg::*;
#(
  parameter int COL_BITS = 11,
  parameter int DQ_LEVEL = 1,
  parameter int A        = 26
) (
  input  logic [A-1:0]        addr,
  input  logic [REM_BITS-1:0] remaining,
  output logic [8:0]          n,
  output logic [7:0]          len_m1
);

  localparam int BC_BITS = COL_BITS - 1;
  localparam int W       = (COL_BITS > REM_BITS) ? COL_BITS + 1 : REM_BITS + 1;

  logic [BC_BITS-1:0] bc;
  logic [W-1:0]       room;
  logic [W-1:0]       lim;
  logic               unused_addr_bits;

  // Only the beat-column bits matter; bank, row and sub-beat bits are ignored.
  assign bc               = addr[COL_BITS+DQ_LEVEL-2 : DQ_LEVEL];
  assign unused_addr_bits = ^addr;

  // Three-way minimum; a zero remaining count never reaches this block.
  always_comb begin
    room = W'(beats_per_row(COL_BITS)) - W'(bc);
    lim  = W'(remaining);
    if (W'(MAX_BURST) < lim) begin
      lim = W'(MAX_BURST);
    end
    if (room < lim) begin
      lim = room;
    end
    n      = 9'(lim);
    len_m1 = 8'(lim - W'(1));
  end

endmodule

// File: rtl/ddr_burst_splitter.sv
// Front-end that cuts long client read/write requests into controller
// bursts of at most 256 beats that never cross a DRAM row. One sub-burst is
// outstanding at a time; data is passed straight through in both directions.
module ddr_burst_splitter
  import ddr_cfg_pkg::*;
#(
  parameter int BA_BITS  = 2,
  parameter int ROW_BITS = 13,
  parameter int COL_BITS = 11,
  parameter int DQ_LEVEL = 1
) (
  input logic            core_clk,
  input logic            core_clk_rstn,
  ddr_burst_splitter_if.slave bus
);

  localparam int A = addr_width(BA_BITS, ROW_BITS, COL_BITS, DQ_LEVEL);

  split_state_t        state;
  split_state_t        state_next;

  logic                is_write;
  logic [A-1:0]        cur_addr;
  logic [REM_BITS-1:0] remaining;
  logic [8:0]          n_q;
  logic [7:0]          len_q;
  logic [7:0]          beat_cnt;

  logic [8:0]          n_calc;
  logic [7:0]          len_calc;

  logic                last_sub;
  logic                w_hs;
  logic                r_hs;
  logic [A-1:0]        next_addr;
  logic [REM_BITS-1:0] next_remaining;

  ddr_split_calc #(
    .COL_BITS (COL_BITS),
    .DQ_LEVEL (DQ_LEVEL),
    .A        (A)
  ) u_calc (
    .addr      (cur_addr),
    .remaining (remaining),
    .n         (n_calc),
    .len_m1    (len_calc)
  );

  // The current sub-burst is the final one when it covers everything left.
  assign last_sub       = (remaining == REM_BITS'(n_q));
  assign w_hs           = (state == ST_WDATA) && bus.s_wvalid && bus.wready;
  assign r_hs           = (state == ST_RDATA) && bus.rvalid && bus.s_rready;
  assign next_addr      = cur_addr + (A'(n_q) << DQ_LEVEL);
  assign next_remaining = remaining - REM_BITS'(n_q);

  // State register; reset drops any transfer in flight straight back to idle.
  always_ff @(posedge core_clk or negedge core_clk_rstn) begin
    if (!core_clk_rstn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and all outputs; every output is zero unless its state drives it.
  always_comb begin
    state_next   = state;
    bus.cmd_ready = 1'b0;
    bus.cmd_done  = 1'b0;
    bus.s_wready  = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rlast   = 1'b0;
    bus.s_rdata   = '0;
    bus.awvalid   = 1'b0;
    bus.awaddr    = '0;
    bus.awlen     = '0;
    bus.wvalid    = 1'b0;
    bus.wlast     = 1'b0;
    bus.wdata     = '0;
    bus.bready    = 1'b0;
    bus.arvalid   = 1'b0;
    bus.araddr    = '0;
    bus.arlen     = '0;
    bus.rready    = 1'b0;

    case (state)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          state_next = ST_CALC;
        end
      end

      ST_CALC: begin
        state_next = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (is_write) begin
          bus.awvalid = 1'b1;
          bus.awaddr  = cur_addr;
          bus.awlen   = len_q;
          if (bus.awready) begin
            state_next = ST_WDATA;
          end
        end else begin
          bus.arvalid = 1'b1;
          bus.araddr  = cur_addr;
          bus.arlen   = len_q;
          if (bus.arready) begin
            state_next = ST_RDATA;
          end
        end
      end

      ST_WDATA: begin
        bus.wvalid   = bus.s_wvalid;
        bus.s_wready = bus.wready;
        bus.wdata    = bus.s_wdata;
        bus.wlast    = (beat_cnt == len_q);
        if (w_hs && (beat_cnt == len_q)) begin
          state_next = ST_WRESP;
        end
      end

      ST_WRESP: begin
        bus.bready = 1'b1;
        if (bus.bvalid) begin
          state_next = last_sub ? ST_DONE : ST_CALC;
        end
      end

      ST_RDATA: begin
        bus.s_rvalid = bus.rvalid;
        bus.rready   = bus.s_rready;
        bus.s_rdata  = bus.rdata;
        bus.s_rlast  = bus.rlast && last_sub;
        if (r_hs && bus.rlast) begin
          state_next = last_sub ? ST_DONE : ST_CALC;
        end
      end

      ST_DONE: begin
        bus.cmd_done = 1'b1;
        state_next   = ST_IDLE;
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Request bookkeeping: latch the command, size each sub-burst, count beats
  // and advance address/remaining once a sub-burst has fully completed.
  always_ff @(posedge core_clk or negedge core_clk_rstn) begin
    if (!core_clk_rstn) begin
      is_write  <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      n_q       <= '0;
      len_q     <= '0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            is_write  <= bus.cmd_write;
            cur_addr  <= bus.cmd_addr & ~A'((1 << DQ_LEVEL) - 1);
            remaining <= {1'b0, bus.cmd_len} + REM_BITS'(1);
          end
        end

        ST_CALC: begin
          n_q   <= n_calc;
          len_q <= len_calc;
        end

        ST_ISSUE: begin
          beat_cnt <= '0;
        end

        ST_WDATA: begin
          if (w_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
          end
        end

        ST_WRESP: begin
          if (bus.bvalid) begin
            cur_addr  <= next_addr;
            remaining <= next_remaining;
          end
        end

        ST_RDATA: begin
          if (r_hs && bus.rlast) begin
            cur_addr  <= next_addr;
            remaining <= next_remaining;
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_burst_splitter.sv
// Directed bench for ddr_burst_splitter: the bench plays both the client and
// a simple controller, logging every address handshake and data beat.
module tb_ddr_burst_splitter;
  import ddr_cfg_pkg::*;

  localparam int A = 26;
  localparam int D = 16;

  logic core_clk      = 1'b0;
  logic core_clk_rstn = 1'b0;

  always #5 core_clk = ~core_clk;

  ddr_burst_splitter_if bus ();

  ddr_burst_splitter dut (
    .core_clk      (core_clk),
    .core_clk_rstn (core_clk_rstn),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [A-1:0] a_addr_log [16];
  logic [7:0]   a_len_log  [16];
  int a_cnt, b_cnt, w_cnt, r_cnt, done_cnt;
  int acc_cyc, first_a_cyc, last_b_cyc, done_cyc;

  // Single comparison point: counts and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Park every bench-driven signal at zero.
  task automatic clearInputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.s_wvalid  = 1'b0;
    bus.s_wdata   = '0;
    bus.s_rready  = 1'b0;
    bus.awready   = 1'b0;
    bus.wready    = 1'b0;
    bus.bvalid    = 1'b0;
    bus.arready   = 1'b0;
    bus.rvalid    = 1'b0;
    bus.rlast     = 1'b0;
    bus.rdata     = '0;
  endtask

  // Run one client command cycle by cycle. Inputs change at the falling edge,
  // outputs are observed 1 ns later and handshakes are booked for the next
  // rising edge. With abort set, reset is pulled during the 2nd write burst.
  task automatic applyStimulus(input logic wr, input logic [A-1:0] addr,
                               input logic [11:0] len, input int aw_delay,
                               input bit w_toggle, input int stall_beat,
                               input bit abort);
    int total, a_wait, burst_beat, r_left, r_gen, wc_cnt, stall_left;
    bit cmd_sent, holding, b_pend, wtog, stall_done;
    logic [A-1:0] hold_addr, obs_addr;
    logic [7:0]   hold_len, obs_len, cur_len;

    total = int'(len) + 1;
    a_cnt = 0; b_cnt = 0; w_cnt = 0; r_cnt = 0; done_cnt = 0;
    acc_cyc = -1; first_a_cyc = -1; last_b_cyc = -1; done_cyc = -1;
    a_wait = 0; burst_beat = 0; r_left = 0; r_gen = 0; wc_cnt = 0; stall_left = 0;
    cmd_sent = 0; holding = 0; b_pend = 0; wtog = 0; stall_done = 0;
    hold_addr = '0; hold_len = '0; cur_len = '0;

    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge core_clk);

      if (abort && (a_cnt == 2) && (burst_beat == 3)) begin
        bus.cmd_valid = 1'b1;
        bus.s_wvalid  = 1'b1;
        bus.s_rready  = 1'b1;
        bus.awready   = 1'b1;
        bus.wready    = 1'b1;
        bus.bvalid    = 1'b1;
        bus.arready   = 1'b1;
        bus.rvalid    = 1'b1;
        bus.rlast     = 1'b1;
        core_clk_rstn = 1'b0;
        #1;
        checkOutput("abort_cmd_ready", bus.cmd_ready, 1);
        checkOutput("abort_cmd_done",  bus.cmd_done,  0);
        checkOutput("abort_awvalid",   bus.awvalid,   0);
        checkOutput("abort_awaddr",    bus.awaddr,    0);
        checkOutput("abort_wvalid",    bus.wvalid,    0);
        checkOutput("abort_wlast",     bus.wlast,     0);
        checkOutput("abort_s_wready",  bus.s_wready,  0);
        checkOutput("abort_bready",    bus.bready,    0);
        checkOutput("abort_arvalid",   bus.arvalid,   0);
        checkOutput("abort_rready",    bus.rready,    0);
        checkOutput("abort_s_rvalid",  bus.s_rvalid,  0);
        break;
      end

      // Client side
      bus.cmd_valid = !cmd_sent;
      bus.cmd_write = wr;
      bus.cmd_addr  = addr;
      bus.cmd_len   = len;
      bus.s_wvalid  = wr && (wc_cnt < total);
      bus.s_wdata   = 16'h1000 + 16'(wc_cnt);
      if (!stall_done && (stall_beat >= 0) && (r_cnt == stall_beat)) begin
        stall_left = 3;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        bus.s_rready = 1'b0;
        stall_left--;
      end else begin
        bus.s_rready = 1'b1;
      end

      // Controller side
      bus.awready = bus.awvalid && (a_wait >= aw_delay);
      bus.arready = bus.arvalid && (a_wait >= aw_delay);
      wtog        = w_toggle ? ~wtog : 1'b1;
      bus.wready  = wtog;
      bus.bvalid  = b_pend;
      bus.rvalid  = (r_left > 0);
      bus.rlast   = (r_left == 1);
      bus.rdata   = 16'hA000 + 16'(r_gen);

      #1;

      if (bus.cmd_valid && bus.cmd_ready) begin
        cmd_sent = 1;
        acc_cyc  = cyc;
      end else if (cmd_sent) begin
        checkOutput("cmd_ready_busy", bus.cmd_ready, 0);
      end

      if (bus.awvalid || bus.arvalid) begin
        if (first_a_cyc < 0) first_a_cyc = cyc;
        obs_addr = wr ? bus.awaddr : bus.araddr;
        obs_len  = wr ? bus.awlen  : bus.arlen;
        if (holding) begin
          checkOutput("a_addr_stable", obs_addr, hold_addr);
          checkOutput("a_len_stable",  obs_len,  hold_len);
        end
        holding   = 1;
        hold_addr = obs_addr;
        hold_len  = obs_len;
        a_wait++;
        if (bus.awready || bus.arready) begin
          if (a_cnt < 16) begin
            a_addr_log[a_cnt] = obs_addr;
            a_len_log[a_cnt]  = obs_len;
          end
          a_cnt++;
          holding    = 0;
          a_wait     = 0;
          burst_beat = 0;
          cur_len    = obs_len;
          if (!wr) r_left = int'(obs_len) + 1;
        end
      end

      if (bus.bvalid && bus.bready) begin
        b_pend     = 0;
        b_cnt++;
        last_b_cyc = cyc;
      end

      if (bus.s_wready) begin
        checkOutput("s_wready_needs_aw", a_cnt > b_cnt, 1);
      end

      if (bus.wvalid && bus.wready) begin
        checkOutput("w_needs_aw", a_cnt > b_cnt, 1);
        checkOutput("wdata", bus.wdata, 16'h1000 + 16'(w_cnt));
        checkOutput("wlast", bus.wlast, burst_beat == int'(cur_len));
        if (bus.wlast) b_pend = 1;
        burst_beat++;
        w_cnt++;
      end
      if (bus.s_wvalid && bus.s_wready) wc_cnt++;

      if (bus.rvalid) begin
        checkOutput("rready_follow", bus.rready, bus.s_rready);
      end
      if (bus.s_rvalid && bus.s_rready) begin
        checkOutput("s_rdata", bus.s_rdata, 16'hA000 + 16'(r_cnt));
        checkOutput("s_rlast", bus.s_rlast, r_cnt == total - 1);
        r_cnt++;
      end
      if (bus.rvalid && bus.rready) begin
        r_left--;
        r_gen++;
      end

      if (bus.cmd_done) begin
        done_cnt++;
        done_cyc = cyc;
        break;
      end
    end

    if (done_cnt > 0) begin
      bus.cmd_valid = 1'b0;
      @(negedge core_clk);
      #1;
      checkOutput("done_one_cycle",   bus.cmd_done,  0);
      checkOutput("ready_after_done", bus.cmd_ready, 1);
    end
  endtask

  initial begin
    clearInputs();
    core_clk_rstn = 1'b0;
    repeat (3) @(negedge core_clk);
    #1;
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    checkOutput("rst_cmd_done",  bus.cmd_done,  0);
    checkOutput("rst_awvalid",   bus.awvalid,   0);
    checkOutput("rst_arvalid",   bus.arvalid,   0);
    checkOutput("rst_s_wready",  bus.s_wready,  0);
    checkOutput("rst_bready",    bus.bready,    0);
    core_clk_rstn = 1'b1;

    $display("[TB] single write 0x0 len 9");
    applyStimulus(1'b1, 26'h0, 12'd9, 0, 1'b0, -1, 1'b0);
    checkOutput("t1_done",      done_cnt, 1);
    checkOutput("t1_aw_cnt",    a_cnt, 1);
    checkOutput("t1_awaddr",    a_addr_log[0], 26'h0);
    checkOutput("t1_awlen",     a_len_log[0], 8'd9);
    checkOutput("t1_w_beats",   w_cnt, 10);
    checkOutput("t1_b_cnt",     b_cnt, 1);
    checkOutput("t1_issue_lat", first_a_cyc - acc_cyc, 2);
    checkOutput("t1_done_lat",  done_cyc - last_b_cyc, 1);

    $display("[TB] split write 0x0 len 599");
    applyStimulus(1'b1, 26'h0, 12'd599, 0, 1'b0, -1, 1'b0);
    checkOutput("t2_done",    done_cnt, 1);
    checkOutput("t2_aw_cnt",  a_cnt, 3);
    checkOutput("t2_awaddr0", a_addr_log[0], 26'h000);
    checkOutput("t2_awaddr1", a_addr_log[1], 26'h200);
    checkOutput("t2_awaddr2", a_addr_log[2], 26'h400);
    checkOutput("t2_awlen0",  a_len_log[0], 8'd255);
    checkOutput("t2_awlen1",  a_len_log[1], 8'd255);
    checkOutput("t2_awlen2",  a_len_log[2], 8'd87);
    checkOutput("t2_w_beats", w_cnt, 600);
    checkOutput("t2_b_cnt",   b_cnt, 3);

    $display("[TB] row-crossing read 0x7F0 len 19");
    applyStimulus(1'b0, 26'h7F0, 12'd19, 0, 1'b0, -1, 1'b0);
    checkOutput("t3_done",    done_cnt, 1);
    checkOutput("t3_ar_cnt",  a_cnt, 2);
    checkOutput("t3_araddr0", a_addr_log[0], 26'h7F0);
    checkOutput("t3_arlen0",  a_len_log[0], 8'd7);
    checkOutput("t3_araddr1", a_addr_log[1], 26'h800);
    checkOutput("t3_arlen1",  a_len_log[1], 8'd11);
    checkOutput("t3_r_beats", r_cnt, 20);
    checkOutput("t3_issue_lat", first_a_cyc - acc_cyc, 2);

    $display("[TB] write with slow awready and toggling wready, odd address");
    applyStimulus(1'b1, 26'h41, 12'd20, 5, 1'b1, -1, 1'b0);
    checkOutput("t4_done",    done_cnt, 1);
    checkOutput("t4_aw_cnt",  a_cnt, 1);
    checkOutput("t4_awaddr",  a_addr_log[0], 26'h40);
    checkOutput("t4_awlen",   a_len_log[0], 8'd20);
    checkOutput("t4_w_beats", w_cnt, 21);
    checkOutput("t4_b_cnt",   b_cnt, 1);

    $display("[TB] read with client stall mid-burst");
    applyStimulus(1'b0, 26'h100, 12'd15, 0, 1'b0, 5, 1'b0);
    checkOutput("t5_done",    done_cnt, 1);
    checkOutput("t5_arlen",   a_len_log[0], 8'd15);
    checkOutput("t5_r_beats", r_cnt, 16);

    $display("[TB] reset during second write sub-burst");
    applyStimulus(1'b1, 26'h0, 12'd599, 0, 1'b0, -1, 1'b1);
    checkOutput("t6_no_done", done_cnt, 0);
    checkOutput("t6_aw_cnt",  a_cnt, 2);
    repeat (2) @(negedge core_clk);
    clearInputs();
    core_clk_rstn = 1'b1;
    @(negedge core_clk);
    #1;
    checkOutput("t6_ready_release", bus.cmd_ready, 1);
    checkOutput("t6_done_release",  bus.cmd_done,  0);

    applyStimulus(1'b0, 26'h10, 12'd0, 0, 1'b0, -1, 1'b0);
    checkOutput("t6_read_done",   done_cnt, 1);
    checkOutput("t6_read_ar_cnt", a_cnt, 1);
    checkOutput("t6_read_araddr", a_addr_log[0], 26'h10);
    checkOutput("t6_read_arlen",  a_len_log[0], 8'd0);
    checkOutput("t6_read_beats",  r_cnt, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
